// File: rtl/vend_dispense_ctrl.sv
// Dispense controller: turns vend/change requests from the coin FSM into
// timed solenoid and hopper pulses, confirms each item through its drop
// sensor, tracks bottle and coin stock and stops in FAULT when a mechanism
// never reports a delivery.
module vend_dispense_ctrl #(
  parameter int CNT_W          = 8,
  parameter int BOTTLE_INIT    = 8,
  parameter int COIN_INIT      = 16,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vend_req,
  input  logic [1:0]       change_req,
  input  logic             bottle_sense,
  input  logic             coin_sense,
  input  logic             refill,
  input  logic             fault_clr,
  output logic             bottle_drop,
  output logic             coin_kick,
  output logic             busy,
  output logic             done,
  output logic             sold_out,
  output logic             change_short,
  output logic             overrun,
  output logic             fault,
  output logic [CNT_W-1:0] bottle_cnt,
  output logic [CNT_W-1:0] coin_cnt
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    B_PULSE = 3'd1,
    B_WAIT  = 3'd2,
    C_PULSE = 3'd3,
    C_WAIT  = 3'd4,
    FAULT   = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    pcnt, pcnt_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [1:0]       job_coins, job_coins_n;
  logic             pend_valid, pend_valid_n;
  logic             pend_bottle, pend_bottle_n;
  logic [1:0]       pend_coins, pend_coins_n;
  logic [CNT_W-1:0] bottle_cnt_n, coin_cnt_n;
  logic             sold_out_n, change_short_n, overrun_n;

  logic [1:0]       req_coins;
  logic             req_now;
  logic             launch;
  logic             launch_bottle;
  logic [1:0]       launch_coins;

  // Next-state logic: request capture, job launch, pulse/wait sequencing and stock updates
  always_comb begin
    req_coins      = (change_req == 2'b01) ? 2'd1 :
                     (change_req == 2'b10) ? 2'd2 : 2'd0;
    req_now        = vend_req || (req_coins != 2'd0);
    launch         = 1'b0;
    launch_bottle  = 1'b0;
    launch_coins   = 2'd0;
    state_n        = state;
    pcnt_n         = pcnt;
    tcnt_n         = tcnt;
    job_coins_n    = job_coins;
    pend_valid_n   = pend_valid;
    pend_bottle_n  = pend_bottle;
    pend_coins_n   = pend_coins;
    bottle_cnt_n   = bottle_cnt;
    coin_cnt_n     = coin_cnt;
    sold_out_n     = sold_out;
    change_short_n = change_short;
    overrun_n      = overrun;

    if (state != IDLE && req_now) begin
      if (pend_valid) begin
        overrun_n = 1'b1;
      end else begin
        pend_valid_n  = 1'b1;
        pend_bottle_n = vend_req;
        pend_coins_n  = req_coins;
      end
    end

    case (state)
      IDLE: begin
        if (refill) begin
          bottle_cnt_n   = CNT_W'(BOTTLE_INIT);
          coin_cnt_n     = CNT_W'(COIN_INIT);
          sold_out_n     = 1'b0;
          change_short_n = 1'b0;
        end
        if (pend_valid) begin
          launch        = 1'b1;
          launch_bottle = pend_bottle;
          launch_coins  = pend_coins;
          pend_valid_n  = req_now;
          pend_bottle_n = vend_req;
          pend_coins_n  = req_coins;
        end else if (req_now) begin
          launch        = 1'b1;
          launch_bottle = vend_req;
          launch_coins  = req_coins;
        end
        if (launch) begin
          job_coins_n = launch_coins;
          pcnt_n      = '0;
          if (launch_bottle) begin
            state_n = B_PULSE;
          end else if (launch_coins != 2'd0) begin
            state_n = C_PULSE;
          end
        end
      end

      B_PULSE: begin
        if (bottle_cnt == '0) begin
          sold_out_n = 1'b1;
          pcnt_n     = '0;
          state_n    = (job_coins != 2'd0) ? C_PULSE : IDLE;
        end else if (pcnt == PW'(PULSE_CYCLES - 1)) begin
          tcnt_n  = '0;
          state_n = B_WAIT;
        end else begin
          pcnt_n = pcnt + PW'(1);
        end
      end

      B_WAIT: begin
        if (bottle_sense) begin
          if (bottle_cnt != '0) begin
            bottle_cnt_n = bottle_cnt - CNT_W'(1);
          end
          pcnt_n  = '0;
          state_n = (job_coins != 2'd0) ? C_PULSE : IDLE;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = FAULT;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end

      C_PULSE: begin
        if (coin_cnt == '0) begin
          change_short_n = 1'b1;
          job_coins_n    = 2'd0;
          state_n        = IDLE;
        end else if (pcnt == PW'(PULSE_CYCLES - 1)) begin
          tcnt_n  = '0;
          state_n = C_WAIT;
        end else begin
          pcnt_n = pcnt + PW'(1);
        end
      end

      C_WAIT: begin
        if (coin_sense) begin
          if (coin_cnt != '0) begin
            coin_cnt_n = coin_cnt - CNT_W'(1);
          end
          job_coins_n = job_coins - 2'd1;
          pcnt_n      = '0;
          state_n     = (job_coins > 2'd1) ? C_PULSE : IDLE;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = FAULT;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end

      FAULT: begin
        if (fault_clr) begin
          job_coins_n = 2'd0;
          state_n     = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered outputs; actuator drives follow the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pcnt         <= '0;
      tcnt         <= '0;
      job_coins    <= 2'd0;
      pend_valid   <= 1'b0;
      pend_bottle  <= 1'b0;
      pend_coins   <= 2'd0;
      bottle_cnt   <= CNT_W'(BOTTLE_INIT);
      coin_cnt     <= CNT_W'(COIN_INIT);
      sold_out     <= 1'b0;
      change_short <= 1'b0;
      overrun      <= 1'b0;
      bottle_drop  <= 1'b0;
      coin_kick    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      pcnt         <= pcnt_n;
      tcnt         <= tcnt_n;
      job_coins    <= job_coins_n;
      pend_valid   <= pend_valid_n;
      pend_bottle  <= pend_bottle_n;
      pend_coins   <= pend_coins_n;
      bottle_cnt   <= bottle_cnt_n;
      coin_cnt     <= coin_cnt_n;
      sold_out     <= sold_out_n;
      change_short <= change_short_n;
      overrun      <= overrun_n;
      bottle_drop  <= (state_n == B_PULSE) && (bottle_cnt_n != '0);
      coin_kick    <= (state_n == C_PULSE) && (coin_cnt_n != '0);
      busy         <= (state_n != IDLE);
      done         <= (state != IDLE) && (state != FAULT) && (state_n == IDLE);
      fault        <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Randomized bench for the dispense controller. A job-level model (a queue of
// items still to deliver, each either pulsing or waiting for its sensor)
// predicts every output cycle by cycle.
module tb_vend_dispense_ctrl;

  localparam int CNT_W          = 8;
  localparam int BOTTLE_INIT    = 8;
  localparam int COIN_INIT      = 16;
  localparam int PULSE_CYCLES   = 4;
  localparam int TIMEOUT_CYCLES = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             vend_req;
  logic [1:0]       change_req;
  logic             bottle_sense;
  logic             coin_sense;
  logic             refill;
  logic             fault_clr;
  logic             bottle_drop;
  logic             coin_kick;
  logic             busy;
  logic             done;
  logic             sold_out;
  logic             change_short;
  logic             overrun;
  logic             fault;
  logic [CNT_W-1:0] bottle_cnt;
  logic [CNT_W-1:0] coin_cnt;

  int errorCount = 0;
  int checkCount = 0;

  vend_dispense_ctrl #(
    .CNT_W(CNT_W), .BOTTLE_INIT(BOTTLE_INIT), .COIN_INIT(COIN_INIT),
    .PULSE_CYCLES(PULSE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .vend_req(vend_req), .change_req(change_req),
    .bottle_sense(bottle_sense), .coin_sense(coin_sense), .refill(refill),
    .fault_clr(fault_clr), .bottle_drop(bottle_drop), .coin_kick(coin_kick),
    .busy(busy), .done(done), .sold_out(sold_out), .change_short(change_short),
    .overrun(overrun), .fault(fault), .bottle_cnt(bottle_cnt), .coin_cnt(coin_cnt)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Model: items[] holds what the active job still has to deliver (0 = bottle, 1 = coin)
  int mBottle, mCoin, pendC, mPulseLeft, mAge;
  bit mSold, mShort, mOver, mBusy, mFault, mInWait, mDone, pendV, pendB;
  int items[$];

  function automatic void modelReset();
    mBottle = BOTTLE_INIT; mCoin = COIN_INIT;
    mSold = 0; mShort = 0; mOver = 0; mBusy = 0; mFault = 0;
    mInWait = 0; mDone = 0; pendV = 0; pendB = 0; pendC = 0;
    mPulseLeft = 0; mAge = 0;
    items.delete();
  endfunction

  function automatic void nextItem();
    if (items.size() == 0) begin
      mBusy = 0;
      mDone = 1;
    end else begin
      mInWait = 0;
      mPulseLeft = PULSE_CYCLES;
    end
  endfunction

  function automatic void startJob(input bit b, input int c);
    items.delete();
    if (b) items.push_back(0);
    for (int i = 0; i < c; i++) items.push_back(1);
    mBusy = 1;
    mInWait = 0;
    mPulseLeft = PULSE_CYCLES;
  endfunction

  function automatic void modelStep();
    int coins = (change_req == 2'b01) ? 1 : (change_req == 2'b10) ? 2 : 0;
    bit req = vend_req || (coins > 0);
    bit sense;
    int stock;
    mDone = 0;
    if (!mBusy) begin
      if (refill) begin
        mBottle = BOTTLE_INIT; mCoin = COIN_INIT; mSold = 0; mShort = 0;
      end
      if (pendV) begin
        startJob(pendB, pendC);
        pendV = req; pendB = vend_req; pendC = coins;
      end else if (req) begin
        startJob(vend_req, coins);
      end
    end else begin
      if (req) begin
        if (pendV) mOver = 1;
        else begin pendV = 1; pendB = vend_req; pendC = coins; end
      end
      if (mFault) begin
        if (fault_clr) begin mFault = 0; mBusy = 0; items.delete(); end
      end else begin
        stock = (items[0] == 0) ? mBottle : mCoin;
        if (!mInWait) begin
          if (stock == 0) begin
            if (items[0] == 0) begin mSold = 1; void'(items.pop_front()); end
            else begin mShort = 1; items.delete(); end
            nextItem();
          end else begin
            mPulseLeft--;
            if (mPulseLeft == 0) begin mInWait = 1; mAge = 0; end
          end
        end else begin
          sense = (items[0] == 0) ? bottle_sense : coin_sense;
          if (sense) begin
            if (items[0] == 0) begin if (mBottle > 0) mBottle--; end
            else if (mCoin > 0) mCoin--;
            void'(items.pop_front());
            nextItem();
          end else begin
            mAge++;
            if (mAge == TIMEOUT_CYCLES) mFault = 1;
          end
        end
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic compareAll();
    bit pulsing = mBusy && !mFault && !mInWait && (items.size() > 0);
    bit eDrop = pulsing && (items[0] == 0) && (mBottle > 0);
    bit eKick = pulsing && (items[0] == 1) && (mCoin > 0);
    checkOutput("bottle_drop", 32'(bottle_drop), 32'(eDrop));
    checkOutput("coin_kick", 32'(coin_kick), 32'(eKick));
    checkOutput("busy", 32'(busy), 32'(mBusy));
    checkOutput("done", 32'(done), 32'(mDone));
    checkOutput("fault", 32'(fault), 32'(mFault));
    checkOutput("sold_out", 32'(sold_out), 32'(mSold));
    checkOutput("change_short", 32'(change_short), 32'(mShort));
    checkOutput("overrun", 32'(overrun), 32'(mOver));
    checkOutput("bottle_cnt", 32'(bottle_cnt), 32'(mBottle));
    checkOutput("coin_cnt", 32'(coin_cnt), 32'(mCoin));
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] c, input bit bs,
                               input bit cs, input bit rf, input bit fc);
    @(negedge clk);
    vend_req = v; change_req = c; bottle_sense = bs;
    coin_sense = cs; refill = rf; fault_clr = fc;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  int reqPct, sensePct, refillPct;

  // Reset check, randomized segments with varying load and sensor health, then async reset mid coin pulse
  initial begin
    rst = 1'b1;
    vend_req = 0; change_req = 2'b00; bottle_sense = 0;
    coin_sense = 0; refill = 0; fault_clr = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
    rst = 1'b0;

    for (int seg = 0; seg < 12; seg++) begin
      case ($urandom_range(2))
        0: reqPct = 3;
        1: reqPct = 15;
        default: reqPct = 45;
      endcase
      sensePct  = (seg % 4 == 3) ? 0 : (($urandom_range(1) == 0) ? 20 : 50);
      refillPct = (seg % 3 == 1) ? 0 : 4;
      for (int cyc = 0; cyc < 250; cyc++) begin
        applyStimulus($urandom_range(99) < reqPct,
                      ($urandom_range(99) < reqPct) ? 2'($urandom_range(3)) : 2'b00,
                      $urandom_range(99) < sensePct,
                      $urandom_range(99) < sensePct,
                      $urandom_range(99) < refillPct,
                      $urandom_range(99) < 10);
      end
    end

    @(negedge clk);
    rst = 1'b1;
    modelReset();
    #1;
    compareAll();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 2'b01, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 2'b00, 0, 1, 0, 0);
    applyStimulus(0, 2'b10, 0, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    compareAll();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
